// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clear/arm, capture start/stop fine codes and coarse count, emit one result word.
// Optional multi-hot detection is enabled by defining TDC_MEAS_CTRL_MULTIHOT_CHK_EN.
module tdc_meas_ctrl #(
   parameter int START_W     = 204,
   parameter int STOP_W      = 176,
   parameter int CNT_W       = 48,
   parameter int IDX_W       = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               arm,
   input  logic               continuous,
   input  logic [START_W-1:0] one_hot_start,
   input  logic [STOP_W-1:0]  one_hot_stop,
   input  logic [CNT_W-1:0]   out_count,
   output logic               tdc_clear,
   output logic               busy,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CNT_W-1:0]   res_coarse,
   output logic [IDX_W-1:0]   res_fine_start,
   output logic [IDX_W-1:0]   res_fine_stop,
   output logic               res_timeout,
   output logic               res_err
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_START,
      S_WAIT_STOP,
      S_RESULT
   } state_t;

   state_t state, next_state;

   logic [TO_W-1:0]  tcnt;
   logic [CNT_W-1:0] count_start;
   logic [IDX_W-1:0] idx_start;
   logic [IDX_W-1:0] enc_start_idx, enc_stop_idx;
   logic start_hit, stop_hit, to_hit, handshake;
   logic start_cap, stop_cap, to_cap;

   // Lowest set bit wins; the loop runs high-to-low so the last match is the lowest.
   function automatic logic [IDX_W-1:0] enc_start(input logic [START_W-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = START_W - 1; i >= 0; i--)
         if (v[i]) idx = IDX_W'(i);
      return idx;
   endfunction

   function automatic logic [IDX_W-1:0] enc_stop(input logic [STOP_W-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = STOP_W - 1; i >= 0; i--)
         if (v[i]) idx = IDX_W'(i);
      return idx;
   endfunction

   assign enc_start_idx = enc_start(one_hot_start);
   assign enc_stop_idx  = enc_stop(one_hot_stop);
   assign start_hit     = |one_hot_start;
   assign stop_hit      = |one_hot_stop;
   assign to_hit        = (tcnt == TO_W'(TIMEOUT_CYC - 1));
   assign handshake     = (state == S_RESULT) && res_ready;
   assign start_cap     = (state == S_WAIT_START) && start_hit;
   assign stop_cap      = (state == S_WAIT_STOP) && stop_hit;
   assign to_cap        = (state == S_WAIT_STOP) && !stop_hit && to_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:       if (arm) next_state = S_CLEAR;
         S_CLEAR:      next_state = S_WAIT_START;
         S_WAIT_START: if (start_hit) next_state = stop_hit ? S_RESULT : S_WAIT_STOP;
         S_WAIT_STOP:  if (stop_hit || to_hit) next_state = S_RESULT;
         S_RESULT:     if (handshake) next_state = continuous ? S_CLEAR : S_IDLE;
         default:      next_state = S_IDLE;
      endcase
   end

   always_comb begin
      tdc_clear = (state == S_CLEAR);
      busy      = (state != S_IDLE);
      res_valid = (state == S_RESULT);
   end

   // Result registers only change on entry to RESULT, so they hold through back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt           <= '0;
         count_start    <= '0;
         idx_start      <= '0;
         res_coarse     <= '0;
         res_fine_start <= '0;
         res_fine_stop  <= '0;
         res_timeout    <= 1'b0;
      end else if (start_cap) begin
         tcnt        <= '0;
         count_start <= out_count;
         idx_start   <= enc_start_idx;
         if (stop_hit) begin
            res_coarse     <= '0;
            res_fine_start <= enc_start_idx;
            res_fine_stop  <= enc_stop_idx;
            res_timeout    <= 1'b0;
         end
      end else if (stop_cap) begin
         res_coarse     <= out_count - count_start;
         res_fine_start <= idx_start;
         res_fine_stop  <= enc_stop_idx;
         res_timeout    <= 1'b0;
      end else if (to_cap) begin
         res_coarse     <= '0;
         res_fine_start <= idx_start;
         res_fine_stop  <= '0;
         res_timeout    <= 1'b1;
      end else if (state == S_WAIT_STOP) begin
         tcnt <= tcnt + TO_W'(1);
      end
   end

`ifdef TDC_MEAS_CTRL_MULTIHOT_CHK_EN
   logic multi_start, multi_stop, err_start, err_q;

   // v & (v-1) clears the lowest set bit; anything left means more than one bit was set.
   assign multi_start = |(one_hot_start & (one_hot_start - START_W'(1)));
   assign multi_stop  = |(one_hot_stop & (one_hot_stop - STOP_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_start <= 1'b0;
         err_q     <= 1'b0;
      end else if (start_cap) begin
         err_start <= multi_start;
         if (stop_hit) err_q <= multi_start | multi_stop;
      end else if (stop_cap) begin
         err_q <= err_start | multi_stop;
      end else if (to_cap) begin
         err_q <= err_start;
      end
   end

   assign res_err = err_q;
`else
   assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed testbench for tdc_meas_ctrl; expected values are hand-computed per scenario.
module tb_tdc_meas_ctrl;

   localparam int START_W = 204;
   localparam int STOP_W  = 176;
   localparam int CNT_W   = 48;
   localparam int IDX_W   = 8;
   localparam int TO_CYC  = 1000;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               arm, continuous, res_ready;
   logic [START_W-1:0] one_hot_start;
   logic [STOP_W-1:0]  one_hot_stop;
   logic [CNT_W-1:0]   out_count;
   logic               tdc_clear, busy, res_valid, res_timeout, res_err;
   logic [CNT_W-1:0]   res_coarse;
   logic [IDX_W-1:0]   res_fine_start, res_fine_stop;

   int checks = 0;
   int errors = 0;

`ifdef TDC_MEAS_CTRL_MULTIHOT_CHK_EN
   localparam logic EXP_MULTI_ERR = 1'b1;
`else
   localparam logic EXP_MULTI_ERR = 1'b0;
`endif

   tdc_meas_ctrl #(
      .START_W(START_W), .STOP_W(STOP_W), .CNT_W(CNT_W), .IDX_W(IDX_W), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .continuous(continuous),
      .one_hot_start(one_hot_start), .one_hot_stop(one_hot_stop), .out_count(out_count),
      .tdc_clear(tdc_clear), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_coarse(res_coarse), .res_fine_start(res_fine_start), .res_fine_stop(res_fine_stop),
      .res_timeout(res_timeout), .res_err(res_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=<500us", $time);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Arm from IDLE and advance to WAIT_START.
   task automatic do_arm();
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      step(1);
   endtask

   task automatic do_handshake();
      res_ready = 1'b1;
      step(1);
      res_ready = 1'b0;
      one_hot_start = '0;
      one_hot_stop  = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      arm = 1'b0; continuous = 1'b0; res_ready = 1'b0;
      one_hot_start = '0; one_hot_stop = '0; out_count = '0;
      step(3);
      checks++;
      if ({tdc_clear, busy, res_valid, res_timeout, res_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: clr/busy/vld/to/err=%b required=00000",
                  {tdc_clear, busy, res_valid, res_timeout, res_err});
      end
      checks++;
      if (res_coarse !== '0 || res_fine_start !== '0 || res_fine_stop !== '0) begin
         errors++;
         $display("FAIL reset_data: coarse=%0d fs=%0d fp=%0d required=0/0/0",
                  res_coarse, res_fine_start, res_fine_stop);
      end
      rst_n = 1'b1;
      step(2);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: busy=%b required=0", busy);
      end
   endtask

   task automatic test_basic();
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      checks++;
      if (tdc_clear !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_clear_pulse: clr=%b busy=%b required=1/1", tdc_clear, busy);
      end
      step(1);
      checks++;
      if (tdc_clear !== 1'b0) begin
         errors++;
         $display("FAIL basic_clear_width: clr=%b required=0", tdc_clear);
      end
      one_hot_start = '0; one_hot_start[17] = 1'b1; out_count = 48'd100;
      step(1);
      one_hot_stop = '0; one_hot_stop[42] = 1'b1; out_count = 48'd137;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_wait_stop: res_valid=%b required=0", res_valid);
      end
      step(1);
      checks++;
      if (res_valid !== 1'b1 || res_coarse !== 48'd37 || res_fine_start !== 8'd17 ||
          res_fine_stop !== 8'd42 || res_timeout !== 1'b0 || res_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: vld=%b coarse=%0d fs=%0d fp=%0d to=%b err=%b required=1/37/17/42/0/0",
                  res_valid, res_coarse, res_fine_start, res_fine_stop, res_timeout, res_err);
      end
      do_handshake();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || res_coarse !== 48'd37) begin
         errors++;
         $display("FAIL basic_after_hs: vld=%b busy=%b coarse=%0d required=0/0/37",
                  res_valid, busy, res_coarse);
      end
   endtask

   task automatic test_wrap();
      do_arm();
      one_hot_start = '0; one_hot_start[0] = 1'b1; out_count = 48'hFFFF_FFFF_FFFD;
      step(1);
      one_hot_stop = '0; one_hot_stop[175] = 1'b1; out_count = 48'd4;
      step(1);
      checks++;
      if (res_valid !== 1'b1 || res_coarse !== 48'd7 || res_fine_start !== 8'd0 ||
          res_fine_stop !== 8'd175) begin
         errors++;
         $display("FAIL wrap_result: vld=%b coarse=%0d fs=%0d fp=%0d required=1/7/0/175",
                  res_valid, res_coarse, res_fine_start, res_fine_stop);
      end
      do_handshake();
   endtask

   task automatic test_timeout();
      int n;
      do_arm();
      one_hot_start = '0; one_hot_start[203] = 1'b1; out_count = 48'd500;
      step(1);
      n = 0;
      while (res_valid !== 1'b1 && n < 3000) begin
         out_count = out_count + 48'd1;
         step(1);
         n++;
      end
      checks++;
      if (n !== TO_CYC) begin
         errors++;
         $display("FAIL timeout_latency: cycles=%0d required=%0d", n, TO_CYC);
      end
      checks++;
      if (res_timeout !== 1'b1 || res_coarse !== '0 || res_fine_stop !== '0 ||
          res_fine_start !== 8'd203) begin
         errors++;
         $display("FAIL timeout_result: to=%b coarse=%0d fp=%0d fs=%0d required=1/0/0/203",
                  res_timeout, res_coarse, res_fine_stop, res_fine_start);
      end
      do_handshake();
   endtask

   task automatic test_same_cycle();
      int bad;
      do_arm();
      one_hot_start = '0; one_hot_start[5] = 1'b1;
      one_hot_stop  = '0; one_hot_stop[9]  = 1'b1;
      out_count = 48'd55;
      step(1);
      checks++;
      if (res_valid !== 1'b1 || res_coarse !== '0 || res_fine_start !== 8'd5 ||
          res_fine_stop !== 8'd9 || res_timeout !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_result: vld=%b coarse=%0d fs=%0d fp=%0d to=%b required=1/0/5/9/0",
                  res_valid, res_coarse, res_fine_start, res_fine_stop, res_timeout);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         out_count = out_count + 48'd13;
         one_hot_stop = '0; one_hot_stop[i + 1] = 1'b1;
         step(1);
         if (res_valid !== 1'b1 || res_coarse !== '0 || res_fine_start !== 8'd5 ||
             res_fine_stop !== 8'd9) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL same_cycle_hold: unstable_cycles=%0d required=0", bad);
      end
      do_handshake();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_to_idle: busy=%b vld=%b required=0/0", busy, res_valid);
      end
   endtask

   task automatic test_back_to_back();
      int clears, results;
      clears = 0;
      results = 0;
      continuous = 1'b1;
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      if (tdc_clear === 1'b1) clears++;
      step(1);
      for (int h = 0; h < 3; h++) begin
         one_hot_start = '0; one_hot_start[10 + h] = 1'b1; out_count = CNT_W'(1000 * (h + 1));
         step(1);
         arm = 1'b1;
         one_hot_stop = '0; one_hot_stop[20 + h] = 1'b1; out_count = CNT_W'(1000 * (h + 1) + h + 3);
         step(1);
         arm = 1'b0;
         if (res_valid === 1'b1 && res_coarse === CNT_W'(h + 3) &&
             res_fine_start === IDX_W'(10 + h) && res_fine_stop === IDX_W'(20 + h)) results++;
         if (h == 2) continuous = 1'b0;
         do_handshake();
         if (h < 2) begin
            if (tdc_clear === 1'b1) clears++;
            step(1);
         end
      end
      checks++;
      if (results !== 3) begin
         errors++;
         $display("FAIL b2b_results: correct=%0d required=3", results);
      end
      checks++;
      if (clears !== 3) begin
         errors++;
         $display("FAIL b2b_clears: pulses=%0d required=3", clears);
      end
      step(1);
      checks++;
      if (busy !== 1'b0 || tdc_clear !== 1'b0) begin
         errors++;
         $display("FAIL b2b_arm_dropped: busy=%b clr=%b required=0/0", busy, tdc_clear);
      end
   endtask

   task automatic test_reset_mid();
      do_arm();
      one_hot_start = '0; one_hot_start[1] = 1'b1; out_count = 48'd7;
      step(1);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tdc_clear, busy, res_valid, res_timeout} !== 4'b0 || res_coarse !== '0 ||
          res_fine_start !== '0 || res_fine_stop !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: clr/busy/vld/to=%b coarse=%0d fs=%0d fp=%0d required=0000/0/0/0",
                  {tdc_clear, busy, res_valid, res_timeout}, res_coarse, res_fine_start, res_fine_stop);
      end
      step(2);
      rst_n = 1'b1;
      one_hot_stop = '0; one_hot_stop[3] = 1'b1;
      step(3);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_result: vld=%b busy=%b required=0/0", res_valid, busy);
      end
      one_hot_start = '0;
      one_hot_stop  = '0;
   endtask

   task automatic test_multihot();
      do_arm();
      one_hot_start = '0; one_hot_start[3] = 1'b1; one_hot_start[8] = 1'b1; out_count = 48'd20;
      step(1);
      one_hot_stop = '0; one_hot_stop[2] = 1'b1; out_count = 48'd31;
      step(1);
      checks++;
      if (res_fine_start !== 8'd3 || res_fine_stop !== 8'd2 || res_coarse !== 48'd11) begin
         errors++;
         $display("FAIL multihot_index: fs=%0d fp=%0d coarse=%0d required=3/2/11",
                  res_fine_start, res_fine_stop, res_coarse);
      end
      checks++;
      if (res_err !== EXP_MULTI_ERR) begin
         errors++;
         $display("FAIL multihot_err: err=%b required=%b", res_err, EXP_MULTI_ERR);
      end
      do_handshake();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_timeout();
      test_same_cycle();
      test_back_to_back();
      test_reset_mid();
      test_multihot();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC core. Clears and arms the TDC, waits for the start and stop fine codes, encodes the one-hot vectors to bin indices, and latches the coarse counter at each event. It then delivers one result word per measurement over a valid/ready handshake. It sits between the TDC instance (clk domain, 100 MHz) and the readout/UART logic.

## Interface
- START_W, 204: width of `one_hot_start`.
- STOP_W, 176: width of `one_hot_stop`.
- CNT_W, 48: width of `out_count` and `res_coarse`.
- IDX_W, 8: fine index width; must satisfy 2^IDX_W > max(START_W, STOP_W).
- TIMEOUT_CYC, 1000: clk cycles allowed in WAIT_STOP before abort.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle request to start a measurement; ignored unless IDLE.
- continuous  in  1  sampled in RESULT at handshake; 1 = re-arm automatically.
- one_hot_start  in  START_W  TDC start fine code, held by TDC until cleared; all-zero = no event.
- one_hot_stop  in  STOP_W  TDC stop fine code, same hold rule.
- out_count  in  CNT_W  TDC free-running coarse counter.
- tdc_clear  out  1  one-cycle pulse clearing the TDC fine-code latches.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result when high with res_valid.
- res_coarse  out  CNT_W  count_stop − count_start, modulo 2^CNT_W.
- res_fine_start  out  IDX_W  index of lowest set bit of captured start code.
- res_fine_stop  out  IDX_W  index of lowest set bit of captured stop code.
- res_timeout  out  1  stop not seen within TIMEOUT_CYC.
- res_err  out  1  multi-hot code detected (see Configuration).

## Operation
- States: IDLE, CLEAR, WAIT_START, WAIT_STOP, RESULT.
- IDLE: on arm=1 → CLEAR.
- CLEAR: tdc_clear=1 for exactly this cycle → WAIT_START.
- WAIT_START: when one_hot_start≠0, capture out_count as count_start and start index → WAIT_STOP, timeout counter cleared to 0.
  - If one_hot_stop≠0 in the same cycle, capture both and go directly to RESULT. res_coarse=0.
- WAIT_STOP: timeout counter increments each cycle.
  - When one_hot_stop≠0: capture count_stop and stop index → RESULT.
  - When the counter reaches TIMEOUT_CYC−1 with no stop: → RESULT with res_timeout=1, res_fine_stop=0, res_coarse=0.
  - A stop in the same cycle as the timeout has priority; it is a normal result.
- No timeout in WAIT_START; the block waits indefinitely.
- RESULT: res_valid=1. Outputs are stable until the handshake (res_valid & res_ready).
  - At handshake with continuous=1 → CLEAR.
  - At handshake with continuous=0 → IDLE.
- arm in any state other than IDLE is dropped, not queued.
- Coarse subtraction is unsigned CNT_W modulo, so counter wrap between start and stop gives the correct difference.
- Index encoder: priority on the lowest set bit. A zero vector never reaches the encoder output path.

## Timing
- Reset: state=IDLE, tdc_clear=0, busy=0, res_valid=0, all res_* = 0, counters 0.
- Reset asserted mid-measurement aborts immediately. No result is emitted after release.
- arm at edge k → tdc_clear high in cycle k+1 → WAIT_START from edge k+2.
- Start seen at edge s → WAIT_STOP after edge s. Stop seen at edge p → res_valid high after edge p (1-cycle latency).
- Minimum measurement period in continuous mode: handshake edge → CLEAR → WAIT_START, i.e. 2 cycles of dead time.
- res_valid deasserts after the handshake edge. Result registers keep their last value until the next capture.

## Configuration
- TDC_MEAS_CTRL_MULTIHOT_CHK_EN defined: at each capture, a population check on the captured vector sets res_err=1 if more than one bit is set. The index still reports the lowest set bit.
- Not defined: res_err is tied to 0 and no population logic is synthesized.

## Test plan
- Reset then arm; start one-hot bit 17 with out_count=100; stop bit 42 with out_count=137 → tdc_clear pulse 1 cycle after arm; res_coarse=37, fine_start=17, fine_stop=42, timeout=0, err=0.
- Start with out_count=2^48−3, stop with out_count=4 → res_coarse=7.
- Start only, TIMEOUT_CYC=1000, no stop → res_valid exactly 1000 cycles after start capture; res_timeout=1, res_coarse=0.
- Start bit 5 and stop bit 9 asserted in the same cycle → direct to RESULT; res_coarse=0, fine 5/9. Then hold res_ready=0 for 10 cycles → outputs stable, then handshake → IDLE.
- continuous=1 with three back-to-back hits → three results and three tdc_clear pulses. Extra arm while busy → no effect. rst_n low during WAIT_STOP → all outputs 0, no res_valid.
- Macro defined, start code with bits 3 and 8 set → fine_start=3, res_err=1. Macro undefined → res_err=0.
